// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor, WIDTH bits, optional signed-overflow flag (macro KS_OVF_EN).
// Latency: L = 1 + ceil(clog2(WIDTH)/PIPE_EVERY) cycles from accept to out_valid; one beat per cycle at full rate.
// Backpressure: global advance en = ~out_valid | out_ready; when low every stage holds; in_ready = en.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (A, B, Cin, SUB)
//   out_valid/out_ready  result handshake (X, Cout, OVF when KS_OVF_EN is defined)
//   SUB=0: {Cout,X} = A + B + Cin;  SUB=1: {Cout,X} = A + ~B + 1 (Cout=1 means no borrow)
module ks_adder_pipe #(
  parameter int WIDTH      = 16,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             Cout
`ifdef KS_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  logic             en;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0;

  // Stage registers: stage s holds the (G,P) state entering prefix levels
  // s*PIPE_EVERY .. (s+1)*PIPE_EVERY-1, plus the half-sum and carry-in
  // that the final XOR needs.
  logic [WIDTH-1:0] st_g  [NSTG];
  logic [WIDTH-1:0] st_p  [NSTG];
  logic [WIDTH-1:0] st_p0 [NSTG];
  logic             st_c0 [NSTG];
  logic             st_v  [NSTG];

  // Combinational prefix result at the output of each stage.
  logic [WIDTH-1:0] pf_g [NSTG];
  logic [WIDTH-1:0] pf_p [NSTG];
  logic [WIDTH-1:0] car;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Operand conditioning. The carry-in is folded straight into bit 0's
  // generate, so after the prefix tree G[i] is the carry out of bit i.
  always_comb begin
    bx      = SUB ? ~B : B;
    c0      = SUB | Cin;
    p_in    = A ^ bx;
    g_in    = A & bx;
    g_in[0] = g_in[0] | (p_in[0] & c0);
  end

  // Kogge-Stone levels, PIPE_EVERY of them per stage, at distance 2^l.
  // Bits below the distance pass through: their G is already complete,
  // and P is padded with ones so it combines as identity.
  always_comb begin : prefix
    logic [WIDTH-1:0] g_w;
    logic [WIDTH-1:0] p_w;
    int               d;
    g_w = '0;
    p_w = '0;
    d   = 0;
    for (int s = 0; s < NSTG; s++) begin
      g_w = st_g[s];
      p_w = st_p[s];
      for (int l = s * PIPE_EVERY; (l < (s + 1) * PIPE_EVERY) && (l < LEVELS); l++) begin
        d   = 1 << l;
        g_w = g_w | (p_w & (g_w << d));
        p_w = p_w & ((p_w << d) | ~({WIDTH{1'b1}} << d));
      end
      pf_g[s] = g_w;
      pf_p[s] = p_w;
    end
  end

  assign car = pf_g[NSTG-1];

  // Only valid bits and the output register are reset; data registers load
  // only when a valid beat moves into them, otherwise they keep old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v[0] <= 1'b0;
    end else if (en) begin
      st_v[0] <= in_valid;
    end
    if (en && in_valid) begin
      st_g[0]  <= g_in;
      st_p[0]  <= p_in;
      st_p0[0] <= p_in;
      st_c0[0] <= c0;
    end

    for (int s = 1; s < NSTG; s++) begin
      if (rst) begin
        st_v[s] <= 1'b0;
      end else if (en) begin
        st_v[s] <= st_v[s-1];
      end
      if (en && st_v[s-1]) begin
        st_g[s]  <= pf_g[s-1];
        st_p[s]  <= pf_p[s-1];
        st_p0[s] <= st_p0[s-1];
        st_c0[s] <= st_c0[s-1];
      end
    end

    if (rst) begin
      out_valid <= 1'b0;
      X         <= '0;
      Cout      <= 1'b0;
`ifdef KS_OVF_EN
      OVF       <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= st_v[NSTG-1];
      if (st_v[NSTG-1]) begin
        X    <= st_p0[NSTG-1] ^ {car[WIDTH-2:0], st_c0[NSTG-1]};
        Cout <= car[WIDTH-1];
`ifdef KS_OVF_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        OVF  <= car[WIDTH-2] ^ car[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: self-checking bench for ks_adder_pipe (16-bit default plus two 4-bit builds).
// Reference model is plain integer arithmetic on A + Bx + c0 with queue-based scoreboards.
// Works with or without KS_OVF_EN defined.
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 16-bit DUT (defaults)
  logic        v16, rdy16, ov16, ordy16, cin16, sub16, co16, ovf16;
  logic [15:0] a16, b16, x16;

  // 4-bit DUTs: index 0 -> PIPE_EVERY=1, index 1 -> PIPE_EVERY=2
  logic       v4 [2];
  logic       rdy4 [2];
  logic       ov4 [2];
  logic       ordy4 [2];
  logic       cin4 [2];
  logic       sub4 [2];
  logic       co4 [2];
  logic [3:0] a4 [2];
  logic [3:0] b4 [2];
  logic [3:0] x4 [2];
`ifdef KS_OVF_EN
  logic       ovf4 [2];
`endif

  ks_adder_pipe u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .A(a16), .B(b16),
    .Cin(cin16), .SUB(sub16), .out_valid(ov16), .out_ready(ordy16), .X(x16), .Cout(co16)
`ifdef KS_OVF_EN
    , .OVF(ovf16)
`endif
  );

  ks_adder_pipe #(.WIDTH(4), .PIPE_EVERY(1)) u4a (
    .clk(clk), .rst(rst), .in_valid(v4[0]), .in_ready(rdy4[0]), .A(a4[0]), .B(b4[0]),
    .Cin(cin4[0]), .SUB(sub4[0]), .out_valid(ov4[0]), .out_ready(ordy4[0]), .X(x4[0]), .Cout(co4[0])
`ifdef KS_OVF_EN
    , .OVF(ovf4[0])
`endif
  );

  ks_adder_pipe #(.WIDTH(4), .PIPE_EVERY(2)) u4b (
    .clk(clk), .rst(rst), .in_valid(v4[1]), .in_ready(rdy4[1]), .A(a4[1]), .B(b4[1]),
    .Cin(cin4[1]), .SUB(sub4[1]), .out_valid(ov4[1]), .out_ready(ordy4[1]), .X(x4[1]), .Cout(co4[1])
`ifdef KS_OVF_EN
    , .OVF(ovf4[1])
`endif
  );

`ifndef KS_OVF_EN
  assign ovf16 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, x} from unsigned and signed integer sums.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bx;
    logic        c;
    logic [16:0] s;
    int          si;
    bx = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    s  = {1'b0, a} + {1'b0, bx} + {16'd0, c};
    si = int'($signed(a)) + int'($signed(bx)) + (c ? 1 : 0);
    return {(si > 32767) || (si < -32768), s};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic sub);
    int s;
    s = int'(a) + (sub ? 15 - int'(b) : int'(b)) + ((sub || cin) ? 1 : 0);
    return s[4:0];
  endfunction

  // Scoreboard for the 16-bit DUT; also checks stall stability and in_ready.
  logic [17:0] q16 [$];
  logic [17:0] e16, held16;
  logic        hold16 = 1'b0;
  int          n_out16 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      hold16 = 1'b0;
    end else begin
      if (hold16 && ov16) chk("x_stable_in_stall", {14'd0, ovf16, co16, x16}, {14'd0, held16});
      if (ov16 && !ordy16) chk("in_ready_stall", {31'd0, rdy16}, 32'd0);
      if (ov16 && ordy16) begin
        n_out16++;
        chk("u16_result_pending", {31'd0, q16.size() > 0}, 32'd1);
        if (q16.size() > 0) begin
          e16 = q16.pop_front();
          chk("u16_x", {16'd0, x16}, {16'd0, e16[15:0]});
          chk("u16_cout", {31'd0, co16}, {31'd0, e16[16]});
`ifdef KS_OVF_EN
          chk("u16_ovf", {31'd0, ovf16}, {31'd0, e16[17]});
`endif
        end
      end
      hold16 = ov16 && !ordy16;
      held16 = {ovf16, co16, x16};
      if (v16 && rdy16) q16.push_back(ref16(a16, b16, cin16, sub16));
    end
  end

  // Scoreboards for the 4-bit DUTs.
  logic [4:0] q4 [2][$];
  logic [4:0] e4;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q4[k].delete();
      end else begin
        if (ov4[k] && ordy4[k]) begin
          chk(k == 0 ? "u4pe1_pending" : "u4pe2_pending", {31'd0, q4[k].size() > 0}, 32'd1);
          if (q4[k].size() > 0) begin
            e4 = q4[k].pop_front();
            chk(k == 0 ? "u4pe1_sum" : "u4pe2_sum", {27'd0, co4[k], x4[k]}, {27'd0, e4});
          end
        end
        if (v4[k] && rdy4[k]) q4[k].push_back(ref4(a4[k], b4[k], cin4[k], sub4[k]));
      end
    end
  end

  // Single beat into an idle pipe; checks latency 3 and the given result.
  task automatic dir16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] ex, input logic eco, input logic eovf);
    @(posedge clk); #1;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1; ordy16 = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, rdy16}, 32'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_l1"}, {31'd0, ov16}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid_l2"}, {31'd0, ov16}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid_l3"}, {31'd0, ov16}, 32'd1);
    chk({tag, "_x"}, {16'd0, x16}, {16'd0, ex});
    chk({tag, "_cout"}, {31'd0, co16}, {31'd0, eco});
`ifdef KS_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf16}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("note: ovf expectation undefined for %s", tag);
`endif
  endtask

  // Call at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int   guard;
    logic acc;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1; guard = 0;
    do begin
      @(negedge clk);
      acc = rdy16;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) chk("send16_accept", {31'd0, acc}, 32'd1);
    v16 = 1'b0;
  endtask

  task automatic drain16();
    int guard;
    guard = 0;
    while ((q16.size() != 0 || ov16) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain16_empty", q16.size(), 32'd0);
  endtask

  // Latency probe followed by all 1024 operand combinations with random out_ready.
  task automatic exh(input int k, input int lat);
    int   cnt, guard;
    logic acc;
    string nm;
    nm = (k == 0) ? "u4pe1" : "u4pe2";
    @(posedge clk); #1;
    ordy4[k] = 1'b1; a4[k] = 4'h9; b4[k] = 4'h3; cin4[k] = 1'b0; sub4[k] = 1'b0; v4[k] = 1'b1;
    @(posedge clk); #1;
    v4[k] = 1'b0;
    cnt = 1;
    while (cnt < 10) begin
      @(negedge clk);
      if (ov4[k]) break;
      @(posedge clk);
      cnt++;
    end
    chk({nm, "_latency"}, cnt, lat);
    @(posedge clk); #1;
    for (int c = 0; c < 1024; c++) begin
      {sub4[k], cin4[k], a4[k], b4[k]} = 10'(c);
      v4[k] = 1'b1;
      guard = 0;
      do begin
        ordy4[k] = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = rdy4[k];
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        chk({nm, "_accept"}, {31'd0, acc}, 32'd1);
        break;
      end
    end
    v4[k] = 1'b0;
    ordy4[k] = 1'b1;
    guard = 0;
    while ((q4[k].size() != 0 || ov4[k]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_drain_empty"}, q4[k].size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    v16 = 1'b0; ordy16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v4[k] = 1'b0; ordy4[k] = 1'b1; a4[k] = '0; b4[k] = '0; cin4[k] = 1'b0; sub4[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_x", {16'd0, x16}, 32'd0);
    chk("rst_cout", {31'd0, co16}, 32'd0);
`ifdef KS_OVF_EN
    chk("rst_ovf", {31'd0, ovf16}, 32'd0);
`endif
    chk("rst_u4pe1_valid", {31'd0, ov4[0]}, 32'd0);
    chk("rst_u4pe2_valid", {31'd0, ov4[1]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, rdy16}, 32'd1);

    // Directed arithmetic
    dir16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef KS_OVF_EN
    dir16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    dir16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir16("sub_equal", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    dir16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    dir16("add_cin", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    drain16();

    // Back-pressure: 6 back-to-back beats with a 3-cycle consumer stall
    n0 = n_out16;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1 ordy16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ordy16 = 1'b1;
      end
    join
    drain16();
    chk("bp_beat_count", n_out16 - n0, 32'd6);

    // Random traffic with random back-pressure
    n0 = n_out16;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      ordy16 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    v16 = 1'b0; ordy16 = 1'b1;
    drain16();

    // Reset mid-flight: two accepted beats must never emerge
    @(posedge clk); #1;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h3333;
    @(posedge clk); #1;
    v16 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_flight_no_valid", {31'd0, ov16}, 32'd0);
    end
    chk("rst_flight_in_ready", {31'd0, rdy16}, 32'd1);

    // Exhaustive 4-bit, both pipeline spacings in parallel
    fork
      exh(0, 3);
      exh(1, 2);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
